type1_sta_rx: RTL and testbench

Status-frame receiver downstream of the TYPE1 data path. Consumes one 18-bit status stream (MPU or one EX box: `*_sta_dval`/`*_sta_data`) in the 12.5 MHz domain. Checks framing, length and checksum, and keeps the last good frame in a ping-pong buffer for EMIF readout. Flags a missing status frame with a run-cycle watchdog. One instance is used per status stream.

---
 rtl/type1_sta_rx_if.sv | 29 ++
 rtl/type1_sta_rx.sv | 196 +++++++++++++++++++
 tb/tb_type1_sta_rx.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/type1_sta_rx_if.sv
// type1_sta_rx_if: bundles the status-stream input, the run-cycle pulse,
// the EMIF read port and the frame status outputs of one status receiver.
//   master : the side feeding status words and issuing reads.
//   slave  : the receiver itself.
interface type1_sta_rx_if;
  logic        sta_dval;     // input word valid
  logic [17:0] sta_data;     // [17]=SOP, [16]=EOP, [15:0]=payload
  logic        cycle_pulse;  // one pulse per run cycle
  logic        rd_en;        // read strobe
  logic [5:0]  rd_addr;      // word address within the last good frame
  logic        rd_dval;      // read data valid, one clock after rd_en
  logic [15:0] rd_data;      // read data
  logic [6:0]  frm_len;      // length of last good frame, 0 = none yet
  logic        frm_new;      // sticky: good frame since last read of address 0
  logic        frm_ok;       // pulse on a good frame
  logic        frm_err;      // pulse on a bad frame
  logic [7:0]  err_cnt;      // saturating bad-frame count
  logic        sta_timeout;  // watchdog flag

  modport master (
    output sta_dval, sta_data, cycle_pulse, rd_en, rd_addr,
    input  rd_dval, rd_data, frm_len, frm_new, frm_ok, frm_err, err_cnt, sta_timeout
  );

  modport slave (
    input  sta_dval, sta_data, cycle_pulse, rd_en, rd_addr,
    output rd_dval, rd_data, frm_len, frm_new, frm_ok, frm_err, err_cnt, sta_timeout
  );
endinterface

// File: rtl/type1_sta_rx.sv
// type1_sta_rx: receives one 18-bit status stream, checks framing, length
// and a 16-bit wrap-around checksum (last word = sum of all prior payloads),
// and keeps the last good frame in a ping-pong buffer for readout.
// A run-cycle watchdog flags a missing good frame.
// Ports:
//   clk_12_5m : block clock
//   rst_12_5m : asynchronous active-high reset
//   bus       : type1_sta_rx_if.slave (stream in, read port, status out)
module type1_sta_rx #(
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 4
) (
  input  logic            clk_12_5m,
  input  logic            rst_12_5m,
  type1_sta_rx_if.slave   bus
);

  localparam logic [5:0] LAST_IDX = 6'(MAX_LEN - 1);
  localparam logic [3:0] TO_LIMIT = 4'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [15:0] sum_q, sum_d;
  logic        rd_bank_q, rd_bank_d;
  logic [6:0]  frm_len_q, frm_len_d;
  logic        frm_new_q, frm_new_d;
  logic        frm_ok_q, frm_ok_d;
  logic        frm_err_q, frm_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [3:0]  wd_cnt_q, wd_cnt_d;
  logic        sta_timeout_q, sta_timeout_d;
  logic        rd_dval_q, rd_dval_d;
  logic        rd_hit_q, rd_hit_d;

  // Two 64-word banks, addressed as {bank, word}.
  logic [15:0] mem [0:127];
  logic [15:0] mem_rd_q;
  logic        wr_en;
  logic [5:0]  wr_addr;

  logic        sop, eop;
  logic [15:0] pay;

  assign sop = bus.sta_data[17];
  assign eop = bus.sta_data[16];
  assign pay = bus.sta_data[15:0];

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    sum_d     = sum_q;
    rd_bank_d = rd_bank_q;
    frm_len_d = frm_len_q;
    frm_ok_d  = 1'b0;
    frm_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wcnt_q;

    if (bus.sta_dval) begin
      case (state_q)
        RECV: begin
          if (sop) begin
            // Unterminated frame is bad; this word opens the next one.
            frm_err_d = 1'b1;
            if (eop) begin
              state_d = IDLE;
            end else begin
              wr_en   = 1'b1;
              wr_addr = 6'd0;
              wcnt_d  = 6'd1;
              sum_d   = pay;
              state_d = RECV;
            end
          end else if (eop) begin
            state_d = IDLE;
            if (sum_q == pay) begin
              wr_en     = 1'b1;
              rd_bank_d = ~rd_bank_q;
              frm_len_d = {1'b0, wcnt_q} + 7'd1;
              frm_ok_d  = 1'b1;
            end else begin
              frm_err_d = 1'b1;
            end
          end else if (wcnt_q == LAST_IDX) begin
            // No room left for a checksum word.
            frm_err_d = 1'b1;
            state_d   = DROP;
          end else begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + 6'd1;
            sum_d  = sum_q + pay;
          end
        end
        default: begin
          // IDLE and DROP both open a frame on SOP.
          if (sop) begin
            wr_en   = 1'b1;
            wr_addr = 6'd0;
            if (eop) begin
              frm_err_d = 1'b1;
              state_d   = IDLE;
            end else begin
              wcnt_d  = 6'd1;
              sum_d   = pay;
              state_d = RECV;
            end
          end else if (eop) begin
            state_d = IDLE;
          end
        end
      endcase
    end

    // A swap sets frm_new even if address 0 is read in the same cycle.
    frm_new_d = frm_new_q;
    if (frm_ok_d) begin
      frm_new_d = 1'b1;
    end else if (bus.rd_en && (bus.rd_addr == 6'd0)) begin
      frm_new_d = 1'b0;
    end

    err_cnt_d = err_cnt_q;
    if (frm_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    // The visible frm_ok pulse clears the watchdog ahead of cycle_pulse.
    wd_cnt_d = wd_cnt_q;
    if (frm_ok_q) begin
      wd_cnt_d = 4'd0;
    end else if (bus.cycle_pulse && (wd_cnt_q != 4'hF)) begin
      wd_cnt_d = wd_cnt_q + 4'd1;
    end
    sta_timeout_d = (wd_cnt_d >= TO_LIMIT);

    rd_dval_d = bus.rd_en;
    rd_hit_d  = rd_hit_q;
    if (bus.rd_en) begin
      rd_hit_d = ({1'b0, bus.rd_addr} < frm_len_q);
    end
  end

  always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
    if (rst_12_5m) begin
      state_q       <= IDLE;
      wcnt_q        <= 6'd0;
      sum_q         <= 16'd0;
      rd_bank_q     <= 1'b0;
      frm_len_q     <= 7'd0;
      frm_new_q     <= 1'b0;
      frm_ok_q      <= 1'b0;
      frm_err_q     <= 1'b0;
      err_cnt_q     <= 8'd0;
      wd_cnt_q      <= 4'd0;
      sta_timeout_q <= 1'b0;
      rd_dval_q     <= 1'b0;
      rd_hit_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      sum_q         <= sum_d;
      rd_bank_q     <= rd_bank_d;
      frm_len_q     <= frm_len_d;
      frm_new_q     <= frm_new_d;
      frm_ok_q      <= frm_ok_d;
      frm_err_q     <= frm_err_d;
      err_cnt_q     <= err_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      sta_timeout_q <= sta_timeout_d;
      rd_dval_q     <= rd_dval_d;
      rd_hit_q      <= rd_hit_d;
    end
  end

  // Buffer RAM kept free of reset; the out-of-range/reset mask lives in rd_hit_q.
  always_ff @(posedge clk_12_5m) begin
    if (wr_en) begin
      mem[{~rd_bank_q, wr_addr}] <= pay;
    end
    if (bus.rd_en) begin
      mem_rd_q <= mem[{rd_bank_q, bus.rd_addr}];
    end
  end

  assign bus.rd_dval     = rd_dval_q;
  assign bus.rd_data     = rd_hit_q ? mem_rd_q : 16'h0000;
  assign bus.frm_len     = frm_len_q;
  assign bus.frm_new     = frm_new_q;
  assign bus.frm_ok      = frm_ok_q;
  assign bus.frm_err     = frm_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.sta_timeout = sta_timeout_q;

endmodule

// File: tb/tb_type1_sta_rx.sv
// Bench for type1_sta_rx: frames are built at word level, their expected
// outcome (good/bad, length) follows from the frame rules and is queued;
// a monitor pops and compares on every frm_ok/frm_err pulse and rd_dval.
module tb_type1_sta_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #40 clk = ~clk;

  type1_sta_rx_if s();

  type1_sta_rx #(.MAX_LEN(64), .TIMEOUT(4)) dut (
    .clk_12_5m(clk),
    .rst_12_5m(rst),
    .bus(s)
  );

  typedef struct {
    bit ok;
    int len;
  } ev_t;

  ev_t         ev_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] pl_q[$];
  logic [15:0] last_data[64];
  int          last_len = 0;
  int          exp_err  = 0;
  int          checks   = 0;
  int          errors   = 0;
  bit          done     = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit dv, input bit sop, input bit eop, input logic [15:0] p,
                     input bit re, input logic [5:0] ra, input bit cp);
    @(posedge clk);
    #1;
    s.sta_dval    = dv;
    s.sta_data    = {sop, eop, p};
    s.rd_en       = re;
    s.rd_addr     = ra;
    s.cycle_pulse = cp;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b0);
  endtask

  function automatic logic [15:0] model_read(input int a);
    return (a < last_len) ? last_data[a] : 16'h0000;
  endfunction

  task automatic read(input int a);
    rd_q.push_back(model_read(a));
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 6'(a), 1'b0);
  endtask

  // Sends pl_q followed by its checksum (corrupted when badsum).
  task automatic send_frame(input bit badsum, input bit rd0, input bit cp_after);
    int n;
    logic [15:0] sum;
    logic [15:0] ck;
    logic [15:0] w;
    ev_t e;
    n   = pl_q.size() + 1;
    sum = 16'h0;
    foreach (pl_q[i]) sum = sum + pl_q[i];
    ck = badsum ? (sum ^ 16'h0001) : sum;
    e.ok  = (n <= 64) && !badsum;
    e.len = n;
    ev_q.push_back(e);
    if (!e.ok) exp_err++;
    if (rd0) rd_q.push_back(model_read(0));
    for (int i = 0; i < n; i++) begin
      w = (i < n - 1) ? pl_q[i] : ck;
      cyc(1'b1, i == 0, i == n - 1, w, rd0 && (i == n - 1), 6'd0, 1'b0);
    end
    if (e.ok) begin
      last_len = n;
      for (int i = 0; i < n - 1; i++) last_data[i] = pl_q[i];
      last_data[n - 1] = ck;
    end
    if (cp_after) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1);
    idle(1);
  endtask

  // SOP plus k-1 words and no EOP; the next SOP makes it a bad frame.
  task automatic send_abort(input int k);
    ev_t e;
    e.ok  = 1'b0;
    e.len = 0;
    ev_q.push_back(e);
    exp_err++;
    for (int i = 0; i < k; i++) cyc(1'b1, i == 0, 1'b0, 16'($urandom), 1'b0, 6'd0, 1'b0);
  endtask

  task automatic rand_pl(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(16'($urandom));
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 6'd0, 1'b1);
      idle(1);
    end
  endtask

  task automatic chk_err_cnt();
    idle(2);
    @(negedge clk);
    chk("err_cnt", s.err_cnt, (exp_err > 255) ? 255 : exp_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_rd_dval"}, s.rd_dval, 0);
    chk({tag, "_rd_data"}, s.rd_data, 0);
    chk({tag, "_frm_len"}, s.frm_len, 0);
    chk({tag, "_frm_new"}, s.frm_new, 0);
    chk({tag, "_frm_ok"}, s.frm_ok, 0);
    chk({tag, "_frm_err"}, s.frm_err, 0);
    chk({tag, "_err_cnt"}, s.err_cnt, 0);
    chk({tag, "_timeout"}, s.sta_timeout, 0);
  endtask

  task automatic monitor();
    ev_t e;
    logic [15:0] r;
    while (!done) begin
      @(negedge clk);
      if (!rst) begin
        if (s.frm_ok || s.frm_err) begin
          if (ev_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse ok=%0b err=%0b expected none t=%0t",
                     s.frm_ok, s.frm_err, $time);
          end else begin
            e = ev_q.pop_front();
            chk("pulse_ok", s.frm_ok, e.ok);
            chk("pulse_err", s.frm_err, !e.ok);
            if (e.ok) begin
              chk("frm_len", s.frm_len, e.len);
              chk("frm_new_at_ok", s.frm_new, 1);
            end
          end
        end
        if (s.rd_dval) begin
          if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rd_dval data=%0h expected none t=%0t", s.rd_data, $time);
          end else begin
            r = rd_q.pop_front();
            chk("rd_data", s.rd_data, r);
          end
        end
      end
    end
  endtask

  task automatic run();
    s.sta_dval = 1'b0; s.sta_data = '0; s.rd_en = 1'b0; s.rd_addr = '0; s.cycle_pulse = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    // Watchdog threshold and the first good frame.
    pulses(3);
    @(negedge clk); chk("timeout_after3", s.sta_timeout, 0);
    pulses(1);
    @(negedge clk); chk("timeout_after4", s.sta_timeout, 1);
    pl_q = '{16'h0001, 16'h0002, 16'h0003};
    send_frame(1'b0, 1'b0, 1'b1);
    @(negedge clk); chk("timeout_cleared", s.sta_timeout, 0);
    pulses(3);
    @(negedge clk); chk("timeout_coincident3", s.sta_timeout, 0);
    pulses(1);
    @(negedge clk); chk("timeout_coincident4", s.sta_timeout, 1);

    for (int a = 1; a <= 4; a++) read(a);
    idle(2);
    @(negedge clk); chk("frm_new_before_rd0", s.frm_new, 1);
    read(0);
    idle(1);
    @(negedge clk); chk("frm_new_after_rd0", s.frm_new, 0);

    // Bad checksum leaves the previous frame readable.
    pl_q = '{16'h0001, 16'h0002, 16'h0003};
    send_frame(1'b1, 1'b0, 1'b0);
    chk_err_cnt();
    chk("frm_len_kept", s.frm_len, 4);
    for (int a = 0; a <= 4; a++) read(a);

    // Overflow, then a good two-word frame right behind it.
    rand_pl(69);
    send_frame(1'b0, 1'b0, 1'b0);
    pl_q = '{16'hFFFF};
    send_frame(1'b0, 1'b0, 1'b0);
    for (int a = 0; a <= 2; a++) read(a);
    chk_err_cnt();

    // Restart, single-word frame, stray words in IDLE.
    send_abort(3);
    pl_q = '{16'h0010, 16'h0020};
    send_frame(1'b0, 1'b0, 1'b0);
    begin
      ev_t e;
      e.ok = 1'b0; e.len = 0;
      ev_q.push_back(e);
      exp_err++;
      cyc(1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 6'd0, 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 6'd0, 1'b0);
    idle(3);
    chk_err_cnt();

    // Read of address 0 in the swap cycle returns old data, frm_new stays set.
    pl_q = '{16'h0005, 16'h0006};
    send_frame(1'b0, 1'b1, 1'b0);
    idle(2);
    @(negedge clk); chk("frm_new_swap_wins", s.frm_new, 1);
    for (int a = 0; a <= 3; a++) read(a);

    // Reset in the middle of a frame.
    cyc(1'b1, 1'b1, 1'b0, 16'h0100, 1'b0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0200, 1'b0, 6'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0300, 1'b0, 6'd0, 1'b0);
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1;
    s.sta_dval = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_err  = 0;
    last_len = 0;
    chk_reset_outputs("midreset");
    read(0);
    read(5);
    idle(3);

    // Randomized frame mix.
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0)
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 6'd0, 1'b0);
      case (kind)
        0, 1: begin rand_pl($urandom_range(1, 63)); send_frame(1'b0, 1'b0, 1'b0); end
        2:    begin rand_pl($urandom_range(1, 20)); send_frame(1'b1, 1'b0, 1'b0); end
        3:    begin rand_pl($urandom_range(64, 75)); send_frame(1'b0, 1'b0, 1'b0); end
        default: begin
          send_abort($urandom_range(1, 5));
          rand_pl($urandom_range(1, 10));
          send_frame(1'b0, 1'b0, 1'b0);
        end
      endcase
      repeat (3) read($urandom_range(0, 63));
      chk_err_cnt();
    end

    // Error counter saturation.
    for (int i = 0; i < 300; i++) begin
      rand_pl(1);
      send_frame(1'b1, 1'b0, 1'b0);
    end
    chk_err_cnt();

    idle(4);
    chk("ev_queue_empty", ev_q.size(), 0);
    chk("rd_queue_empty", rd_q.size(), 0);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      run();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
